// File: rtl/defunnel_arb_4_1.sv
// Burst-granular round-robin arbiter and per-requester mode scheduler feeding one defunnel input.
// Optional feature: define DEFUNNEL_ARB_PRIO_EN to give requester 0 strict priority over 1..3.
module defunnel_arb_4_1 #(
    parameter int BURST  = 2,
    parameter int BCNT_W = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       t_0_req,
    input  logic       t_1_req,
    input  logic       t_2_req,
    input  logic       t_3_req,
    output logic       t_0_ack,
    output logic       t_1_ack,
    output logic       t_2_ack,
    output logic       t_3_ack,
    output logic       i_req,
    input  logic       i_ack,
    output logic [3:0] grant,
    output logic [7:0] mode,
    input  logic       cfg_req,
    output logic       cfg_ack,
    input  logic [1:0] cfg_sel,
    input  logic [7:0] cfg_mode
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [BCNT_W-1:0] BCNT_ZERO = {BCNT_W{1'b0}};
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST - 1);
    localparam logic [7:0]        MODE_RST  = 8'h01;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        grant_r;
    logic [3:0]        grant_s;
    logic [BCNT_W-1:0] bcnt_r;
    logic [BCNT_W-1:0] bcnt_s;
    logic [1:0]        last_r;
    logic [1:0]        last_s;
    logic [7:0]        mode_r;
    logic [7:0]        mode_s;
    logic [7:0]        mreg_r [4];

    logic [3:0]        req_vec_s;
    logic              owner_req_s;
    logic              xfer_s;
    logic              pick_valid_s;
    logic [1:0]        pick_idx_s;
    logic [2:0]        rr_res_s;
    logic              cfg_we_s;
    logic              cfg_ack_s;
    logic              i_req_s;
    logic [3:0]        ack_s;

    // Round-robin search starting at last+1; returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic       found;
        logic [1:0] pick;
        logic [1:0] cand;
        found = 1'b0;
        pick  = last;
        for (int i = 1; i <= 4; i++) begin
            cand = last + i[1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end else begin
                found = found;
            end
        end
        return {found, pick};
    endfunction

    assign req_vec_s   = {t_3_req, t_2_req, t_1_req, t_0_req};
    assign owner_req_s = |(req_vec_s & grant_r);
    assign xfer_s      = (state_r == ST_BURST) && owner_req_s && i_ack;

    // Arbitration candidate for the next grant.
    always_comb begin
        rr_res_s     = 3'b000;
        pick_valid_s = 1'b0;
        pick_idx_s   = 2'd0;
`ifdef DEFUNNEL_ARB_PRIO_EN
        // Requester 0 is masked out of the rotation; it wins outright when present.
        rr_res_s = rr_pick({req_vec_s[3:1], 1'b0}, last_r);
        if (req_vec_s[0]) begin
            pick_valid_s = 1'b1;
            pick_idx_s   = 2'd0;
        end else begin
            pick_valid_s = rr_res_s[2];
            pick_idx_s   = rr_res_s[1:0];
        end
`else
        rr_res_s     = rr_pick(req_vec_s, last_r);
        pick_valid_s = rr_res_s[2];
        pick_idx_s   = rr_res_s[1:0];
`endif
    end

    // Next-state and handshake decode.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        bcnt_s    = bcnt_r;
        last_s    = last_r;
        mode_s    = mode_r;
        cfg_ack_s = 1'b0;
        cfg_we_s  = 1'b0;
        i_req_s   = 1'b0;
        ack_s     = 4'b0000;
        case (state_r)
            ST_IDLE: begin
                grant_s = 4'b0000;
                if (cfg_req) begin
                    cfg_ack_s = 1'b1;
                    cfg_we_s  = 1'b1;
                end else if (pick_valid_s) begin
                    grant_s = 4'b0001 << pick_idx_s;
                    mode_s  = mreg_r[pick_idx_s];
                    bcnt_s  = BCNT_ZERO;
                    state_s = ST_BURST;
`ifdef DEFUNNEL_ARB_PRIO_EN
                    if (pick_idx_s != 2'd0) begin
                        last_s = pick_idx_s;
                    end else begin
                        last_s = last_r;
                    end
`else
                    last_s = pick_idx_s;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                i_req_s = owner_req_s;
                ack_s   = grant_r & {4{owner_req_s & i_ack}};
                if (xfer_s) begin
                    if (bcnt_r == BCNT_LAST) begin
                        state_s = ST_IDLE;
                        grant_s = 4'b0000;
                        bcnt_s  = BCNT_ZERO;
                    end else begin
                        bcnt_s = bcnt_r + BCNT_ONE;
                    end
                end else begin
                    bcnt_s = bcnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                bcnt_s  = BCNT_ZERO;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            grant_r <= 4'b0000;
            bcnt_r  <= BCNT_ZERO;
            last_r  <= 2'd3;
            mode_r  <= MODE_RST;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            bcnt_r  <= bcnt_s;
            last_r  <= last_s;
            mode_r  <= mode_s;
        end
    end

    // Per-requester mode registers; written only from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                mreg_r[k] <= MODE_RST;
            end
        end else if (cfg_we_s) begin
            mreg_r[cfg_sel] <= cfg_mode;
        end else begin
            for (int k = 0; k < 4; k++) begin
                mreg_r[k] <= mreg_r[k];
            end
        end
    end

    assign t_0_ack = ack_s[0];
    assign t_1_ack = ack_s[1];
    assign t_2_ack = ack_s[2];
    assign t_3_ack = ack_s[3];
    assign i_req   = i_req_s;
    assign cfg_ack = cfg_ack_s;
    assign grant   = grant_r;
    assign mode    = mode_r;

endmodule
